// File: rtl/div_8x4_seq.sv
// div_8x4_seq: sequential restoring divider, 2*DATA_WIDTH-bit dividend by DATA_WIDTH-bit divisor.
// Produces one quotient bit per cycle, MSB first, with valid/ready handshakes on
// both sides. Divide by zero skips the iteration and returns Q=all ones and
// R=A[DATA_WIDTH-1:0] one cycle after accept.
// Optional macro DIV_ZERO_ERR_EN adds a div_zero_err output flagging B==0 results.
module div_8x4_seq #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0]   R
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic                    div_zero_err
`endif
);
  localparam int W  = DATA_WIDTH;
  localparam int QW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [QW-1:0] dvd;
  logic [QW-1:0] quo;
  logic [W-1:0]  dsr;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  rem_next;
  logic [QW-1:0] quo_next;

  // One restoring step: the partial remainder is widened to W+1 bits by the
  // incoming dividend bit, so the compare against B can never overflow, and
  // after a successful subtract the result always fits back into W bits.
  always_comb begin
    shifted  = {rem, dvd[QW-1]};
    ge       = shifted >= {1'b0, dsr};
    rem_next = ge ? W'(shifted - {1'b0, dsr}) : shifted[W-1:0];
    quo_next = {quo[QW-2:0], ge};
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
`ifdef DIV_ZERO_ERR_EN
      div_zero_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd      <= A;
            dsr      <= B;
            in_ready <= 1'b0;
            if (B != '0) begin
              rem   <= '0;
              quo   <= '0;
              cnt   <= CW'(QW);
              state <= CALC;
            end else begin
              Q         <= '1;
              R         <= A[W-1:0];
              out_valid <= 1'b1;
              state     <= DONE;
`ifdef DIV_ZERO_ERR_EN
              div_zero_err <= 1'b1;
`endif
            end
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            Q         <= quo_next;
            R         <= rem_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef DIV_ZERO_ERR_EN
            div_zero_err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_8x4_seq.sv
// tb_div_8x4_seq: directed and soak checks of the sequential 8/4 divider.
module tb_div_8x4_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] b = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] q;
  logic [3:0] r;
`ifdef DIV_ZERO_ERR_EN
  logic       dz;
`endif
  int total = 0;
  int bad = 0;

  div_8x4_seq #(.DATA_WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(a),
    .B(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q(q),
    .R(r)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_zero_err(dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issue one op, measure latency, hold for stall cycles (optionally poking
  // in_valid with A=50,B=5 during the hold), then complete the handshake.
  task automatic run_op(input int ta, input int tb_, input int eq, input int er,
                        input int stall, input bit poke,
                        output int q_o, output int r_o);
    int n;
    q_o = -1;
    r_o = -1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    a = 8'(ta);
    b = 4'(tb_);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 4'($urandom);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("latency", n + 1, (tb_ == 0) ? 1 : 9);
    chk("q", int'(q), eq);
    chk("r", int'(r), er);
    q_o = int'(q);
    r_o = int'(r);
`ifdef DIV_ZERO_ERR_EN
    chk("div_zero_err", int'(dz), int'(tb_ == 0));
`endif
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 8'd50;
        b = 4'd5;
        chk("hold_in_ready", int'(in_ready), 0);
      end
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_q", int'(q), eq);
      chk("hold_r", int'(r), er);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
`ifdef DIV_ZERO_ERR_EN
    chk("post_div_zero_err", int'(dz), 0);
`endif
  endtask

  initial begin
    int rq, rr, sa, sb;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    rst_n = 1'b1;

    run_op(200, 7, 28, 4, 0, 1'b0, rq, rr);
    run_op(255, 15, 17, 0, 0, 1'b0, rq, rr);
    run_op(5, 9, 0, 5, 0, 1'b0, rq, rr);
    run_op(0, 1, 0, 0, 0, 1'b0, rq, rr);
    run_op(8'hA3, 0, 8'hFF, 4'h3, 2, 1'b0, rq, rr);
    run_op(100, 3, 33, 1, 5, 1'b1, rq, rr);
    run_op(50, 5, 10, 0, 0, 1'b0, rq, rr);

    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd77;
    b = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale_valid", int'(out_valid), 0);
    end
    run_op(77, 6, 12, 5, 0, 1'b0, rq, rr);

    for (int i = 0; i < 1000; i++) begin
      sa = int'($urandom_range(0, 255));
      sb = int'($urandom_range(1, 15));
      run_op(sa, sb, sa / sb, sa % sb, int'($urandom_range(0, 3)), 1'b0, rq, rr);
      chk("soak_invariant", rq * sb + rr, sa);
      chk("soak_r_lt_b", int'(rr < sb), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_8x4_seq.md
Name: div_8x4_seq

Overview:
- Sequential restoring divider; the inverse operation of the team's combinational 4x4 multiplier.
- Takes a 2*DATA_WIDTH-bit dividend (a product-width value) and a DATA_WIDTH-bit divisor, and returns quotient and remainder.
- Valid/ready handshake on both sides, so it can sit in a DSP micro-benchmark datapath behind or alongside the multiplier.

Parameters:
- DATA_WIDTH, 4, divisor and remainder width; dividend and quotient width is 2*DATA_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- A  input  2*DATA_WIDTH  dividend.
- B  input  DATA_WIDTH  divisor.
- out_valid  output  1  Q/R valid.
- out_ready  input  1  consumer accepts result.
- Q  output  2*DATA_WIDTH  quotient.
- R  output  DATA_WIDTH  remainder.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, Q=0, R=0, internal iteration counter=0. Any operation in flight is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A and B.
  - If B!=0: clear the partial remainder (DATA_WIDTH+1 bits), load counter=2*DATA_WIDTH, go to CALC.
  - If B==0: go straight to DONE with Q=all ones, R=A[DATA_WIDTH-1:0].
- CALC, one quotient bit per cycle, MSB first:
  - Shift the next dividend bit into the partial remainder.
  - If partial remainder >= B: subtract B and shift 1 into Q; else shift 0 into Q.
  - Decrement the counter. When the counter reaches 0, go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; Q and R are stable and held.
  - On out_ready: out_valid drops next cycle and the block returns to IDLE.
  - in_ready=0 in DONE, so there is no overlap between result hold and new accept.
- Latency, B!=0:
  - Accept edge at cycle 0.
  - CALC occupies cycles 1..2*DATA_WIDTH.
  - out_valid=1 from cycle 2*DATA_WIDTH+1.
  - Default parameter: 9 cycles from accept to out_valid.
- Latency, B==0: out_valid=1 on cycle 1.
- Throughput: at most one operation per (2*DATA_WIDTH+2) cycles with out_ready held high.
- Arithmetic:
  - Unsigned only.
  - Invariant for B!=0: A == Q*B + R and R < B.
  - The partial remainder is DATA_WIDTH+1 bits wide so the compare never overflows.
- Boundary conditions:
  - A=0 yields Q=0, R=0 after the full latency; there is no early exit.
  - Backpressure: out_ready low holds DONE indefinitely with Q/R unchanged.
  - in_valid outside IDLE is ignored. Inputs are sampled only on the accept edge, so A/B may change freely afterwards.
  - rst_n asserted during CALC or DONE aborts the operation. After release the block is in IDLE with out_valid=0 and emits no stale result.

Optional Feature:
- Macro: DIV_ZERO_ERR_EN.
- When defined:
  - Extra output port div_zero_err (1 bit, reset 0).
  - div_zero_err is asserted together with out_valid for a B==0 operation and held while in DONE.
  - It clears on the handshake that leaves DONE.
- When undefined:
  - The port is absent.
  - The B==0 result (Q=all ones, R=A[DATA_WIDTH-1:0], 1-cycle latency) is unchanged.

Test Plan:
- Basic divide: A=200, B=7, out_ready=1 -> out_valid at cycle 9 after accept, Q=28, R=4; in_ready returns 1 the cycle after the output handshake.
- Extremes: A=255, B=15 -> Q=17, R=0. Then A=5, B=9 -> Q=0, R=5. Then A=0, B=1 -> Q=0, R=0, still 9-cycle latency.
- Divide by zero: A=8'hA3, B=0 -> out_valid at cycle 1, Q=8'hFF, R=4'h3. With DIV_ZERO_ERR_EN defined, div_zero_err=1 for the same cycles as out_valid.
- Backpressure and ignored input: A=100, B=3 with out_ready=0 for 5 cycles after out_valid -> Q=33, R=1 held constant. A new in_valid with A=50, B=5 during hold is ignored (in_ready=0); the next accepted op yields Q=10, R=0.
- Reset mid-operation: accept A=77, B=6, assert rst_n=0 at cycle 4 for 2 cycles -> out_valid=0, Q=0, R=0, in_ready=1 immediately. A subsequent op A=77, B=6 yields Q=12, R=5.
- Random soak: 1000 random A/B pairs (B!=0) with random out_ready stalls -> Q*B+R==A and R<B on every handshake; latency always 9 cycles to out_valid.
